// File: rtl/reg_dump_pkg.sv
//-----------------------------------------------------------------------------
// reg_dump_pkg
// Shared types and default widths for the register-dump scanner.
//   dump_state_t : scanner FSM states (IDLE, SETTLE, SEND)
//   DUMP_SEL_W   : default register-select width (core SW input)
//   DUMP_DATA_W  : default display-value width (core OUT output)
//-----------------------------------------------------------------------------
package reg_dump_pkg;

    localparam int DUMP_SEL_W  = 5;
    localparam int DUMP_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SEND
    } dump_state_t;

endpackage

// File: rtl/reg_dump_scanner.sv
//-----------------------------------------------------------------------------
// reg_dump_scanner
// Walks the core's register-display select through every register index on
// a single request, waits a settle interval per index, captures the display
// value and emits it as a valid/ready beat tagged with its index.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   dump_req  in   start a dump (only looked at while idle)
//   sw_sel    out  register select, drives core SW
//   dbg_data  in   display value, from core OUT
//   m_valid   out  capture beat available
//   m_ready   in   downstream accepts beat
//   m_index   out  register index of current beat
//   m_data    out  captured display value
//   busy      out  dump in progress
//   done      out  one-cycle pulse after the last beat is accepted
//-----------------------------------------------------------------------------
module reg_dump_scanner
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int SEL_W         = DUMP_SEL_W,
    parameter int DATA_W        = DUMP_DATA_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_req,
    output logic [SEL_W-1:0]  sw_sel,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [SEL_W-1:0]  m_index,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [SEL_W-1:0]  LAST_IDX    = SEL_W'(NUM_REGS - 1);

    dump_state_t       state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [SEL_W-1:0]  idx, idx_n;
    logic              valid_n;
    logic [SEL_W-1:0]  index_n;
    logic [DATA_W-1:0] data_n;
    logic              busy_n;
    logic              done_n;

    // The walking index is the select itself: both reset to 0, both load 0
    // on a new dump, both step together, and both hold their last value
    // once the dump finishes.
    assign sw_sel = idx;

    // NOTE: every signal gets its hold/default value before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        valid_n = m_valid;
        index_n = m_index;
        data_n  = m_data;
        busy_n  = busy;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (dump_req) begin
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    cnt_n   = SETTLE_LOAD;
                    state_n = SETTLE;
                end
            end

            SETTLE: begin
                cnt_n = cnt - CNT_ONE;
                // Capture on the last settle edge, so the sampled value has
                // had SETTLE_CYCLES edges to follow the select change.
                if (cnt == CNT_ONE) begin
                    data_n  = dbg_data;
                    index_n = idx;
                    valid_n = 1'b1;
                    state_n = SEND;
                end
            end

            SEND: begin
                // m_valid is always high here, so m_ready alone completes
                // the handshake.
                if (m_ready) begin
                    valid_n = 1'b0;
                    if (idx == LAST_IDX) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        idx_n   = idx + SEL_W'(1);
                        cnt_n   = SETTLE_LOAD;
                        state_n = SETTLE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            m_valid <= 1'b0;
            m_index <= '0;
            m_data  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            m_valid <= valid_n;
            m_index <= index_n;
            m_data  <= data_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_reg_dump_scanner.sv
//-----------------------------------------------------------------------------
// tb_reg_dump_scanner
// Two scanners: A with the default 32 registers / 2 settle cycles, fed by a
// core stub whose display value lags the select by one clock; B with 4
// registers / 1 settle cycle, fed combinationally, m_ready tied high.
// Expected beats are queued when a dump is issued; monitors on the falling
// edge pop and compare them as the scanners present output.
//-----------------------------------------------------------------------------
module tb_reg_dump_scanner;
    import reg_dump_pkg::*;

    localparam int N_A = 32;
    localparam int S_A = 2;
    localparam int N_B = 4;
    localparam int S_B = 1;

    typedef struct {
        logic [4:0]  idx;
        logic [15:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- DUT A ----------------
    logic        reset;
    logic        dump_req_a, m_ready_a;
    logic [4:0]  sw_sel_a, m_index_a;
    logic [15:0] dbg_a, m_data_a;
    logic        m_valid_a, busy_a, done_a;
    logic [15:0] tbl_a [N_A];

    // Core stub with a registered select path: OUT follows SW one clock late.
    always @(posedge clk) dbg_a <= tbl_a[sw_sel_a];

    reg_dump_scanner #(.NUM_REGS(N_A), .SEL_W(5), .DATA_W(16), .SETTLE_CYCLES(S_A)) u_a (
        .clk(clk), .reset(reset), .dump_req(dump_req_a), .sw_sel(sw_sel_a),
        .dbg_data(dbg_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
        .m_index(m_index_a), .m_data(m_data_a), .busy(busy_a), .done(done_a)
    );

    // ---------------- DUT B ----------------
    logic        dump_req_b;
    logic        m_ready_b = 1'b1;
    logic [4:0]  sw_sel_b, m_index_b;
    logic [15:0] dbg_b, m_data_b;
    logic        m_valid_b, busy_b, done_b;

    assign dbg_b = {11'h0A5, sw_sel_b};

    reg_dump_scanner #(.NUM_REGS(N_B), .SEL_W(5), .DATA_W(16), .SETTLE_CYCLES(S_B)) u_b (
        .clk(clk), .reset(reset), .dump_req(dump_req_b), .sw_sel(sw_sel_b),
        .dbg_data(dbg_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .m_index(m_index_b), .m_data(m_data_b), .busy(busy_b), .done(done_b)
    );

    // ---------------- reference model / scoreboard for A ----------------
    bit          mon_en = 1'b0;
    beat_t       sb_a[$];
    bit          mb_busy = 0, mb_valid = 0, mb_done = 0;
    logic [4:0]  mb_sel = '0, mb_idx = '0;
    logic [15:0] mb_dat = '0;
    int          exp_rise = 0;
    int          hs_a = 0, done_cnt_a = 0;

    always @(negedge clk) if (mon_en) begin
        // Compare the state after the most recent edge.
        check("a_busy",    busy_a,    mb_busy);
        check("a_done",    done_a,    mb_done);
        check("a_m_valid", m_valid_a, mb_valid);
        check("a_sw_sel",  sw_sel_a,  mb_sel);
        check("a_m_index", m_index_a, mb_idx);
        check("a_m_data",  m_data_a,  mb_dat);
        if (done_a) done_cnt_a++;
        if (m_valid_a && m_ready_a && !reset) hs_a++;

        // Predict the state after the coming edge.
        if (reset) begin
            sb_a.delete();
            mb_busy = 0; mb_valid = 0; mb_done = 0;
            mb_sel = '0; mb_idx = '0; mb_dat = '0;
        end else begin
            mb_done = 0;
            if (!mb_busy) begin
                if (dump_req_a) begin
                    sb_a.delete();
                    for (int i = 0; i < N_A; i++) sb_a.push_back('{idx: 5'(i), data: tbl_a[i]});
                    mb_busy  = 1;
                    mb_sel   = '0;
                    exp_rise = cyc + 1 + S_A;
                end
            end else if (!mb_valid) begin
                if (cyc + 1 == exp_rise) begin
                    mb_valid = 1;
                    mb_idx   = sb_a[0].idx;
                    mb_dat   = sb_a[0].data;
                end
            end else if (m_ready_a) begin
                void'(sb_a.pop_front());
                mb_valid = 0;
                if (sb_a.size() == 0) begin
                    mb_busy = 0;
                    mb_done = 1;
                end else begin
                    mb_sel   = sb_a[0].idx;
                    exp_rise = cyc + 1 + S_A;
                end
            end
        end
    end

    // ---------------- scoreboard for B ----------------
    beat_t sb_b[$];
    int    b_start = 0, done_cnt_b = 0, beats_b = 0;

    always @(negedge clk) if (mon_en) begin
        beat_t b;
        if (m_valid_b) begin
            if (sb_b.size() == 0) begin
                check("b_queue_depth", sb_b.size(), 1);
            end else begin
                b = sb_b.pop_front();
                beats_b++;
                check("b_m_index", m_index_b, b.idx);
                check("b_m_data",  m_data_b,  b.data);
                check("b_beat_cycle", cyc, b_start + S_B + int'(b.idx) * (S_B + 1));
            end
        end
        if (done_b) begin
            done_cnt_b++;
            check("b_done_cycle", cyc, b_start + N_B * (S_B + 1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic randomize_tbl();
        for (int i = 0; i < N_A; i++) tbl_a[i] = 16'($urandom);
    endtask

    // One dump on A. rdy_pct: chance m_ready is high per cycle; stall7 holds
    // beat 7 for 5 cycles; req3 re-pulses dump_req during beat 3; reset_at
    // asserts reset while settling that index (-1: never).
    task automatic run_dump(input int rdy_pct, input bit stall7, input bit req3, input int reset_at);
        int  n = 0, hold = 0, hs0, dc0;
        bit  reqd = 0, did_reset = 0;
        hs0 = hs_a;
        dc0 = done_cnt_a;
        dump_req_a = 1'b1;
        m_ready_a  = 1'b1;
        @(posedge clk); #1;
        dump_req_a = 1'b0;
        while (mb_busy && n < 3000) begin
            m_ready_a  = ($urandom_range(99) < rdy_pct);
            dump_req_a = 1'b0;
            if (stall7 && m_valid_a && m_index_a == 5'd7) begin
                if (hold < 5) begin
                    m_ready_a = 1'b0;
                    hold++;
                end else begin
                    m_ready_a = 1'b1;
                end
            end
            if (req3 && !reqd && m_valid_a && m_index_a == 5'd3) begin
                dump_req_a = 1'b1;
                reqd = 1;
            end
            if (reset_at >= 0 && busy_a && !m_valid_a && int'(sw_sel_a) == reset_at) begin
                reset = 1'b1;
                did_reset = 1;
            end
            @(posedge clk); #1;
            reset = 1'b0;
            dump_req_a = 1'b0;
            n++;
        end
        check("a_dump_timeout", mb_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        if (did_reset) begin
            check("a_no_done_after_reset", done_cnt_a - dc0, 0);
        end else begin
            check("a_beat_count",  hs_a - hs0, N_A);
            check("a_done_pulses", done_cnt_a - dc0, 1);
        end
        if (stall7) check("a_stall_seen", hold, 5);
    endtask

    initial begin
        reset      = 1'b1;
        dump_req_a = 1'b0;
        m_ready_a  = 1'b0;
        dump_req_b = 1'b0;
        for (int i = 0; i < N_A; i++) tbl_a[i] = 16'h14A0 | 16'(i);

        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Stub table {11'h0A5, idx}, m_ready high.
        run_dump(100, 0, 0, -1);
        // Beat 7 stalled, stray request during beat 3.
        randomize_tbl();
        run_dump(100, 1, 1, -1);
        // Reset while settling index 12, then a clean restart.
        randomize_tbl();
        run_dump(70, 0, 0, 12);
        check("a_busy_after_reset", busy_a, 0);
        randomize_tbl();
        run_dump(100, 0, 0, -1);
        // Random back-pressure.
        for (int k = 0; k < 3; k++) begin
            randomize_tbl();
            run_dump(55, 0, 0, -1);
        end

        // DUT B: 4 registers, 1 settle cycle.
        for (int i = 0; i < N_B; i++) sb_b.push_back('{idx: 5'(i), data: 16'h14A0 | 16'(i)});
        dump_req_b = 1'b1;
        @(posedge clk); #1;
        b_start    = cyc;
        dump_req_b = 1'b0;
        repeat (N_B * (S_B + 1) + 4) @(posedge clk);
        #1;
        check("b_beat_count",  beats_b, N_B);
        check("b_done_pulses", done_cnt_b, 1);
        check("b_busy_idle",   busy_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
